// File: rtl/kb_scan_if.sv
// CPU/receiver-facing signal bundle for kb_scan_controller.
// slave modport is the controller side; master is the driver (receiver + CPU) side.
interface kb_scan_if;
    logic       sc_valid;
    logic [7:0] sc_byte;
    logic       KB_read_en;
    logic       KB_clear;
    logic       KB_status;
    logic [6:0] KB_data;
    logic       buf_full;
    logic       overflow;

    modport slave (
        input  sc_valid, sc_byte, KB_read_en, KB_clear,
        output KB_status, KB_data, buf_full, overflow
    );

    modport master (
        output sc_valid, sc_byte, KB_read_en, KB_clear,
        input  KB_status, KB_data, buf_full, overflow
    );
endinterface

// File: rtl/kb_scan_controller.sv
// PS/2 set-2 scan byte decoder with shift tracking, ASCII lookup and FWFT character FIFO.
// Optional macro KB_REPEAT_FILTER_EN suppresses typematic repeats of the last make code.
module kb_scan_controller #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic     clk,
    input  logic     rst,
    kb_scan_if.slave kb
);
    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t      state, state_n;
    logic        lshift, rshift, shift;
    logic        set_l, set_r, clr_l, clr_r;
    logic        make_char, push_req, is_repeat;
    logic        map_hit;
    logic [6:0]  map_char;
    logic [6:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic        full, empty, pop, push_ok;

    assign shift = lshift | rshift;

    function automatic logic [6:0] letter(input logic [6:0] lc, input logic sh);
        return sh ? lc - 7'h20 : lc;
    endfunction

    function automatic logic [6:0] digit(input logic [6:0] d, input logic [6:0] sym, input logic sh);
        return sh ? sym : d;
    endfunction

    always_comb begin
        map_hit  = 1'b1;
        map_char = '0;
        case (kb.sc_byte)
            8'h1C: map_char = letter(7'h61, shift);
            8'h32: map_char = letter(7'h62, shift);
            8'h21: map_char = letter(7'h63, shift);
            8'h23: map_char = letter(7'h64, shift);
            8'h24: map_char = letter(7'h65, shift);
            8'h2B: map_char = letter(7'h66, shift);
            8'h34: map_char = letter(7'h67, shift);
            8'h33: map_char = letter(7'h68, shift);
            8'h43: map_char = letter(7'h69, shift);
            8'h3B: map_char = letter(7'h6A, shift);
            8'h42: map_char = letter(7'h6B, shift);
            8'h4B: map_char = letter(7'h6C, shift);
            8'h3A: map_char = letter(7'h6D, shift);
            8'h31: map_char = letter(7'h6E, shift);
            8'h44: map_char = letter(7'h6F, shift);
            8'h4D: map_char = letter(7'h70, shift);
            8'h15: map_char = letter(7'h71, shift);
            8'h2D: map_char = letter(7'h72, shift);
            8'h1B: map_char = letter(7'h73, shift);
            8'h2C: map_char = letter(7'h74, shift);
            8'h3C: map_char = letter(7'h75, shift);
            8'h2A: map_char = letter(7'h76, shift);
            8'h1D: map_char = letter(7'h77, shift);
            8'h22: map_char = letter(7'h78, shift);
            8'h35: map_char = letter(7'h79, shift);
            8'h1A: map_char = letter(7'h7A, shift);
            8'h45: map_char = digit(7'h30, 7'h29, shift);
            8'h16: map_char = digit(7'h31, 7'h21, shift);
            8'h1E: map_char = digit(7'h32, 7'h40, shift);
            8'h26: map_char = digit(7'h33, 7'h23, shift);
            8'h25: map_char = digit(7'h34, 7'h24, shift);
            8'h2E: map_char = digit(7'h35, 7'h25, shift);
            8'h36: map_char = digit(7'h36, 7'h5E, shift);
            8'h3D: map_char = digit(7'h37, 7'h26, shift);
            8'h3E: map_char = digit(7'h38, 7'h2A, shift);
            8'h46: map_char = digit(7'h39, 7'h28, shift);
            8'h29: map_char = 7'h20;
            8'h5A: map_char = 7'h0D;
            8'h66: map_char = 7'h08;
            default: map_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        set_l     = 1'b0;
        set_r     = 1'b0;
        clr_l     = 1'b0;
        clr_r     = 1'b0;
        make_char = 1'b0;
        if (kb.sc_valid) begin
            case (state)
                S_IDLE: begin
                    case (kb.sc_byte)
                        8'hF0: state_n = S_BRK;
                        8'hE0: state_n = S_EXT;
                        8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                        8'h12: set_l = 1'b1;
                        8'h59: set_r = 1'b1;
                        default: make_char = map_hit;
                    endcase
                end
                S_BRK: begin
                    clr_l   = (kb.sc_byte == 8'h12);
                    clr_r   = (kb.sc_byte == 8'h59);
                    state_n = S_IDLE;
                end
                S_EXT:     state_n = (kb.sc_byte == 8'hF0) ? S_EXT_BRK : S_IDLE;
                S_EXT_BRK: state_n = S_IDLE;
                default:   state_n = S_IDLE;
            endcase
        end
    end

    assign push_req = make_char & ~is_repeat;

    always_ff @(posedge clk) begin
        if (rst) begin
            lshift <= 1'b0;
            rshift <= 1'b0;
        end else begin
            if (set_l) lshift <= 1'b1;
            if (clr_l) lshift <= 1'b0;
            if (set_r) rshift <= 1'b1;
            if (clr_r) rshift <= 1'b0;
        end
    end

`ifdef KB_REPEAT_FILTER_EN
    logic [7:0] last_make;
    assign is_repeat = (kb.sc_byte == last_make);

    always_ff @(posedge clk) begin
        if (rst || kb.KB_clear)
            last_make <= '0;
        else if (make_char)
            last_make <= kb.sc_byte;
        else if (kb.sc_valid && state == S_BRK && kb.sc_byte == last_make)
            last_make <= '0;
    end
`else
    assign is_repeat = 1'b0;
`endif

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop     = kb.KB_read_en & ~empty;
    // At full a concurrent pop frees the head slot, which wr_ptr already points at.
    assign push_ok = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (push_ok && !kb.KB_clear) mem[wr_ptr] <= map_char;
    end

    always_ff @(posedge clk) begin
        if (rst || kb.KB_clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            kb.overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (pop && !push_ok) count <= count - 1'b1;
            if (push_req && !push_ok) kb.overflow <= 1'b1;
        end
    end

    assign kb.KB_status = ~empty;
    assign kb.buf_full  = full;
    assign kb.KB_data   = empty ? '0 : mem[rd_ptr];
endmodule
